// File: rtl/reg_cmd_sequencer_pkg.sv
// Shared encodings for the register command sequencer: target FunSel codes,
// command opcodes and sequencer states.
`timescale 1ns/1ps
package reg_cmd_sequencer_pkg;

  typedef enum logic [2:0] {
    FS_DEC          = 3'b000,
    FS_INC          = 3'b001,
    FS_LOAD         = 3'b010,
    FS_CLR          = 3'b011,
    FS_LOADLO_CLRHI = 3'b100,
    FS_LOADLO       = 3'b101,
    FS_LOADHI       = 3'b110,
    FS_SEXT         = 3'b111
  } funsel_t;

  typedef enum logic [2:0] {
    OP_NOP        = 3'b000,
    OP_LOAD16     = 3'b001,
    OP_LOAD_BYTES = 3'b010,
    OP_CLEAR      = 3'b011,
    OP_INC_N      = 3'b100,
    OP_DEC_N      = 3'b101,
    OP_SEXT_LOAD  = 3'b110,
    OP_RSVD       = 3'b111
  } cmd_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_ISSUE_HI,
    ST_REPEAT,
    ST_DONE
  } state_t;

  // Repeat ops differ only in the FunSel they hold for every strobe.
  function automatic funsel_t repeat_funsel(input cmd_op_t op);
    return (op == OP_INC_N) ? FS_INC : FS_DEC;
  endfunction

endpackage

// File: rtl/reg_cmd_sequencer.sv
// Expands one register command per handshake into E/FunSel/I strobes for a
// function-select register; all outputs registered, Done pulses once per command.
`timescale 1ns/1ps
module reg_cmd_sequencer
  import reg_cmd_sequencer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             CmdValid,
  output logic             CmdReady,
  input  logic [2:0]       CmdOp,
  input  logic [WIDTH-1:0] CmdData,
  output logic             E,
  output logic [2:0]       FunSel,
  output logic [WIDTH-1:0] I,
  output logic             Busy,
  output logic             Done
);

  state_t           state;
  cmd_op_t          op_q;
  logic [7:0]       data_hi;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] rep_n;

  assign rep_n = CmdData[CNT_W-1:0];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= ST_IDLE;
      op_q     <= OP_NOP;
      data_hi  <= '0;
      cnt      <= '0;
      CmdReady <= 1'b1;
      E        <= 1'b0;
      FunSel   <= FS_DEC;
      I        <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (CmdValid && CmdReady) begin
            op_q     <= cmd_op_t'(CmdOp);
            data_hi  <= CmdData[15:8];
            CmdReady <= 1'b0;
            Busy     <= 1'b1;
            // First strobe is presented straight from the accept edge.
            case (cmd_op_t'(CmdOp))
              OP_LOAD16: begin
                state  <= ST_ISSUE;
                E      <= 1'b1;
                FunSel <= FS_LOAD;
                I      <= CmdData;
              end
              OP_LOAD_BYTES: begin
                state  <= ST_ISSUE;
                E      <= 1'b1;
                FunSel <= FS_LOADLO_CLRHI;
                I      <= {{(WIDTH-8){1'b0}}, CmdData[7:0]};
              end
              OP_CLEAR: begin
                state  <= ST_ISSUE;
                E      <= 1'b1;
                FunSel <= FS_CLR;
                I      <= '0;
              end
              OP_SEXT_LOAD: begin
                state  <= ST_ISSUE;
                E      <= 1'b1;
                FunSel <= FS_SEXT;
                I      <= {{(WIDTH-8){1'b0}}, CmdData[7:0]};
              end
              OP_INC_N, OP_DEC_N: begin
                if (rep_n == '0) begin
                  state <= ST_DONE;
                  Done  <= 1'b1;
                end else begin
                  state  <= ST_REPEAT;
                  E      <= 1'b1;
                  FunSel <= repeat_funsel(cmd_op_t'(CmdOp));
                  I      <= '0;
                  cnt    <= rep_n - CNT_W'(1);
                end
              end
              default: begin
                state <= ST_DONE;
                Done  <= 1'b1;
              end
            endcase
          end
        end

        ST_ISSUE: begin
          if (op_q == OP_LOAD_BYTES) begin
            state  <= ST_ISSUE_HI;
            E      <= 1'b1;
            FunSel <= FS_LOADHI;
            I      <= {{(WIDTH-8){1'b0}}, data_hi};
          end else begin
            state  <= ST_DONE;
            E      <= 1'b0;
            FunSel <= FS_DEC;
            I      <= '0;
            Done   <= 1'b1;
          end
        end

        ST_ISSUE_HI: begin
          state  <= ST_DONE;
          E      <= 1'b0;
          FunSel <= FS_DEC;
          I      <= '0;
          Done   <= 1'b1;
        end

        ST_REPEAT: begin
          // cnt holds the strobes still owed after the one currently on the pins.
          if (cnt == '0) begin
            state  <= ST_DONE;
            E      <= 1'b0;
            FunSel <= FS_DEC;
            I      <= '0;
            Done   <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        ST_DONE: begin
          state    <= ST_IDLE;
          Done     <= 1'b0;
          Busy     <= 1'b0;
          CmdReady <= 1'b1;
        end

        default: begin
          state    <= ST_IDLE;
          E        <= 1'b0;
          FunSel   <= FS_DEC;
          I        <= '0;
          Done     <= 1'b0;
          Busy     <= 1'b0;
          CmdReady <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_cmd_sequencer.sv
// Scoreboard bench for reg_cmd_sequencer driving a behavioural 16-bit
// function-select register as the target.
`timescale 1ns/1ps
module tb_reg_cmd_sequencer;
  import reg_cmd_sequencer_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        CmdValid = 1'b0;
  logic        CmdReady;
  logic [2:0]  CmdOp = 3'b000;
  logic [15:0] CmdData = 16'h0000;
  logic        E;
  logic [2:0]  FunSel;
  logic [15:0] I;
  logic        Busy;
  logic        Done;

  int          n_assert = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [15:0] tgt = 16'h0000;

  typedef struct {
    bit          is_done;
    logic [2:0]  fs;
    logic [15:0] iv;
    logic [15:0] tv;
    int          cyc;
  } ev_t;

  ev_t expq[$];

  reg_cmd_sequencer #(.WIDTH(16), .CNT_W(8)) dut (
    .Clock(Clock), .Reset(Reset), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdOp(CmdOp), .CmdData(CmdData), .E(E), .FunSel(FunSel), .I(I),
    .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  // Target function-select register.
  always @(posedge Clock) begin
    if (E) begin
      case (FunSel)
        3'b000: tgt <= tgt - 16'd1;
        3'b001: tgt <= tgt + 16'd1;
        3'b010: tgt <= I;
        3'b011: tgt <= 16'h0000;
        3'b100: tgt <= {8'h00, I[7:0]};
        3'b101: tgt <= {tgt[15:8], I[7:0]};
        3'b110: tgt <= {I[7:0], tgt[7:0]};
        default: tgt <= {{8{I[7]}}, I[7:0]};
      endcase
    end
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: every strobe and every Done must match the head of the queue.
  always @(negedge Clock) begin
    ev_t ev;
    if (E) begin
      if (expq.size() == 0 || expq[0].is_done) begin
        n_assert++;
        n_fail++;
        $display("FAIL unexpected_strobe: got FunSel=%b I=%h at cycle %0d, required no strobe", FunSel, I, cyc);
      end else begin
        ev = expq.pop_front();
        chk("strobe_funsel", 32'(FunSel), 32'(ev.fs));
        chk("strobe_I", 32'(I), 32'(ev.iv));
        chk("strobe_cycle", cyc, ev.cyc);
        chk("strobe_busy", 32'(Busy), 32'd1);
      end
    end else begin
      chk("idle_funsel", 32'(FunSel), 32'd0);
      chk("idle_I", 32'(I), 32'd0);
    end
    if (Done) begin
      if (expq.size() == 0 || !expq[0].is_done) begin
        n_assert++;
        n_fail++;
        $display("FAIL unexpected_done: got Done=1 at cycle %0d, required no Done", cyc);
      end else begin
        ev = expq.pop_front();
        chk("done_target", 32'(tgt), 32'(ev.tv));
        chk("done_cycle", cyc, ev.cyc);
        chk("done_busy", 32'(Busy), 32'd1);
      end
    end
  end

  // Called on a negedge; returns on the negedge after the accept edge, or once
  // CmdReady is back if wait_ready is set.
  task automatic send(input logic [2:0] op, input logic [15:0] data, input int k,
                      input logic [2:0] fs0, input logic [15:0] i0,
                      input logic [2:0] fs1, input logic [15:0] i1,
                      input bit push_done, input logic [15:0] tv,
                      input bit wait_ready, output int acc);
    int n;
    ev_t ev;
    CmdValid = 1'b1;
    CmdOp    = op;
    CmdData  = data;
    n = 0;
    while (!CmdReady && n < 400) begin
      @(negedge Clock);
      n++;
    end
    if (!CmdReady) begin
      n_assert++;
      n_fail++;
      $display("FAIL accept_timeout: got CmdReady=0 for %0d cycles, required 1", n);
      CmdValid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    for (int j = 0; j < k; j++) begin
      ev.is_done = 1'b0;
      ev.fs      = (j == 0) ? fs0 : fs1;
      ev.iv      = (j == 0) ? i0 : i1;
      ev.tv      = 16'h0000;
      ev.cyc     = acc + j;
      expq.push_back(ev);
    end
    if (push_done) begin
      ev.is_done = 1'b1;
      ev.fs      = 3'b000;
      ev.iv      = 16'h0000;
      ev.tv      = tv;
      ev.cyc     = acc + k;
      expq.push_back(ev);
    end
    @(negedge Clock);
    CmdValid = 1'b0;
    CmdOp    = 3'b000;
    CmdData  = 16'h0000;
    if (wait_ready) begin
      n = 0;
      while (!CmdReady && n < 600) begin
        @(negedge Clock);
        n++;
      end
      chk("ready_return_cycle", cyc, acc + k + 1);
    end
  endtask

  initial begin
    int a1;
    int a2;
    int n;
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    chk("reset_ready", 32'(CmdReady), 32'd1);
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_E", 32'(E), 32'd0);
    chk("reset_done", 32'(Done), 32'd0);
    chk("reset_funsel", 32'(FunSel), 32'd0);
    chk("reset_I", 32'(I), 32'd0);
    Reset = 1'b0;
    @(negedge Clock);

    send(OP_LOAD16, 16'hBEEF, 1, FS_LOAD, 16'hBEEF, FS_LOAD, 16'hBEEF, 1, 16'hBEEF, 1, a1);
    chk("load16_target", 32'(tgt), 32'h0000BEEF);

    send(OP_LOAD16, 16'hFFFF, 1, FS_LOAD, 16'hFFFF, FS_LOAD, 16'hFFFF, 1, 16'hFFFF, 1, a1);
    send(OP_LOAD_BYTES, 16'h12A4, 2, FS_LOADLO_CLRHI, 16'h00A4, FS_LOADHI, 16'h0012, 1, 16'h12A4, 1, a1);
    chk("load_bytes_target", 32'(tgt), 32'h000012A4);

    send(OP_LOAD16, 16'hFFFE, 1, FS_LOAD, 16'hFFFE, FS_LOAD, 16'hFFFE, 1, 16'hFFFE, 1, a1);
    send(OP_INC_N, 16'h0005, 5, FS_INC, 16'h0000, FS_INC, 16'h0000, 1, 16'h0003, 1, a1);
    chk("inc5_target", 32'(tgt), 32'h00000003);
    send(OP_INC_N, 16'h0000, 0, FS_INC, 16'h0000, FS_INC, 16'h0000, 1, 16'h0003, 1, a1);

    send(OP_LOAD16, 16'h0100, 1, FS_LOAD, 16'h0100, FS_LOAD, 16'h0100, 1, 16'h0100, 1, a1);
    send(OP_DEC_N, 16'h00FF, 255, FS_DEC, 16'h0000, FS_DEC, 16'h0000, 1, 16'h0001, 1, a1);
    chk("dec255_target", 32'(tgt), 32'h00000001);

    send(OP_SEXT_LOAD, 16'h0080, 1, FS_SEXT, 16'h0080, FS_SEXT, 16'h0080, 1, 16'hFF80, 1, a1);
    chk("sext_target", 32'(tgt), 32'h0000FF80);
    send(OP_CLEAR, 16'h5555, 1, FS_CLR, 16'h0000, FS_CLR, 16'h0000, 1, 16'h0000, 1, a1);
    chk("clear_target", 32'(tgt), 32'h00000000);
    send(OP_RSVD, 16'h1234, 0, FS_DEC, 16'h0000, FS_DEC, 16'h0000, 1, 16'h0000, 1, a1);
    send(OP_NOP, 16'hABCD, 0, FS_DEC, 16'h0000, FS_DEC, 16'h0000, 1, 16'h0000, 1, a1);

    // Second command is offered while the first is still busy.
    send(OP_LOAD16, 16'h5A5A, 1, FS_LOAD, 16'h5A5A, FS_LOAD, 16'h5A5A, 1, 16'h5A5A, 0, a1);
    chk("held_busy", 32'(Busy), 32'd1);
    send(OP_LOAD16, 16'h0F0F, 1, FS_LOAD, 16'h0F0F, FS_LOAD, 16'h0F0F, 1, 16'h0F0F, 1, a2);
    chk("held_accept_cycle", a2, a1 + 3);
    chk("held_target", 32'(tgt), 32'h00000F0F);

    // Reset after the third strobe of a ten-step decrement.
    send(OP_LOAD16, 16'h0100, 1, FS_LOAD, 16'h0100, FS_LOAD, 16'h0100, 1, 16'h0100, 1, a1);
    send(OP_DEC_N, 16'h000A, 3, FS_DEC, 16'h0000, FS_DEC, 16'h0000, 0, 16'h0000, 0, a1);
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    chk("midreset_E", 32'(E), 32'd0);
    chk("midreset_done", 32'(Done), 32'd0);
    chk("midreset_ready", 32'(CmdReady), 32'd1);
    chk("midreset_busy", 32'(Busy), 32'd0);
    Reset = 1'b0;
    repeat (4) @(negedge Clock);
    chk("midreset_target", 32'(tgt), 32'h000000FD);

    send(OP_LOAD16, 16'h1111, 1, FS_LOAD, 16'h1111, FS_LOAD, 16'h1111, 1, 16'h1111, 1, a1);
    chk("post_reset_target", 32'(tgt), 32'h00001111);

    n = 0;
    while (expq.size() != 0 && n < 50) begin
      @(negedge Clock);
      n++;
    end
    chk("queue_drained", 32'(expq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
